// File: rtl/wave_acq_pkg.sv
// rtl/wave_acq_pkg.sv - shared types and constants for the acquisition sequencer
//
// Purpose: acquisition FSM state encoding, sample/state widths and a small
// state-classification helper used by wave_acq_ctrl and its sub-modules.
package wave_acq_pkg;

  localparam int SAMPLE_W = 8;
  localparam int STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ARM  = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } acq_state_t;

  // States in which accepted samples are written to the waveform RAM.
  function automatic logic is_acq(acq_state_t s);
    return (s == PRE) || (s == ARM) || (s == POST);
  endfunction

endpackage

// File: rtl/wave_acq_ctrl_if.sv
// rtl/wave_acq_ctrl_if.sv - control, RAM write and frame status bundle of wave_acq_ctrl
//
// Purpose: groups the register-block controls, the ADC sample, the RAM write
// port and the frame status into one interface.
// Modports:
//   master - the sequencer: samples/controls in, RAM write + status out
//   slave  - register block / RAM / display side: the mirror image
interface wave_acq_ctrl_if #(
  parameter int DEPTH_W = 10
);
  import wave_acq_pkg::*;

  logic [SAMPLE_W-1:0] ad_data;
  logic [9:0]          deci_rate;
  logic [SAMPLE_W-1:0] trig_level;
  logic                trig_edge;
  logic                wave_run;
  logic                rd_done;

  logic                ram_wr_en;
  logic [DEPTH_W-1:0]  ram_wr_addr;
  logic [SAMPLE_W-1:0] ram_wr_data;
  logic [DEPTH_W-1:0]  trig_addr;
  logic [DEPTH_W-1:0]  start_addr;
  logic                acq_done;
  logic                trig_auto;
  logic [STATE_W-1:0]  acq_state;

  modport master (
    input  ad_data, deci_rate, trig_level, trig_edge, wave_run, rd_done,
    output ram_wr_en, ram_wr_addr, ram_wr_data, trig_addr, start_addr,
           acq_done, trig_auto, acq_state
  );

  modport slave (
    output ad_data, deci_rate, trig_level, trig_edge, wave_run, rd_done,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, trig_addr, start_addr,
           acq_done, trig_auto, acq_state
  );

endinterface

// File: rtl/wave_acq_ctrl_trig_detect.sv
// rtl/wave_acq_ctrl_trig_detect.sv - trigger edge detector (module trig_detect)
//
// Purpose: holds the last accepted sample and compares it with the current one
// against the trigger level.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   sample      current ADC sample
//   sample_vld  sample is accepted this cycle (updates prev)
//   level       trigger threshold
//   rising      1 = rising edge, 0 = falling edge
//   hit         combinational: current sample crosses the level vs prev
module trig_detect
  import wave_acq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_vld,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                rising,
  output logic                hit
);

  logic [SAMPLE_W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
    end else if (sample_vld) begin
      prev <= sample;
    end
  end

  always_comb begin
    if (rising) begin
      hit = (prev < level) && (sample >= level);
    end else begin
      hit = (prev >= level) && (sample < level);
    end
  end

endmodule

// File: rtl/wave_acq_ctrl.sv
// rtl/wave_acq_ctrl.sv - oscilloscope acquisition sequencer (decimate, ring-fill, trigger, freeze)
//
// Purpose: decimates the ADC stream, writes accepted samples into the waveform
// RAM as a ring, freezes the ring with a fixed pre/post trigger split and hands
// the frame to the display reader.
// Ports:
//   clk  sample clock
//   rst  asynchronous active-high reset
//   bus  wave_acq_ctrl_if.master: controls and ad_data in; ram_wr_*, trig_addr,
//        start_addr, acq_done, trig_auto, acq_state out
// Build option: AUTO_TRIG_EN - force a trigger after AUTO_TO accepted ARM samples.
module wave_acq_ctrl
  import wave_acq_pkg::*;
#(
  parameter int DEPTH_W  = 10,
  parameter int PRE_TRIG = 512,
  parameter int AUTO_TO  = 4096
) (
  input  logic             clk,
  input  logic             rst,
  wave_acq_ctrl_if.master  bus
);

  localparam logic [DEPTH_W-1:0] PRE_LAST  = DEPTH_W'(PRE_TRIG - 1);
  // POST writes 2^DEPTH_W - PRE_TRIG - 1 samples; this is the index of the last one.
  localparam logic [DEPTH_W-1:0] POST_LAST = DEPTH_W'((1 << DEPTH_W) - PRE_TRIG - 2);
  localparam logic [DEPTH_W-1:0] PRE_OFS   = DEPTH_W'(PRE_TRIG);

  acq_state_t          state, next_state;
  logic [9:0]          deci_cnt, deci_last;
  logic                accept, wr_fire, hit, auto_hit, trig_fire, enter_pre;
  logic [DEPTH_W-1:0]  wr_ptr, cnt;
  logic                wr_en_q, acq_done_q;
  logic [DEPTH_W-1:0]  wr_addr_q, trig_addr_q, start_addr_q;
  logic [SAMPLE_W-1:0] wr_data_q;

  // deci_rate of 0 behaves as 1 (keep every sample).
  assign deci_last = (bus.deci_rate == 10'd0) ? 10'd0 : bus.deci_rate - 10'd1;
  assign accept    = (deci_cnt == 10'd0);
  // A run drop blocks the write of the sample presented in the same cycle.
  assign wr_fire   = accept && bus.wave_run && is_acq(state);
  assign trig_fire = wr_fire && (state == ARM) && (hit || auto_hit);
  assign enter_pre = (next_state == PRE) && (state != PRE);

  trig_detect u_trig (
    .clk        (clk),
    .rst        (rst),
    .sample     (bus.ad_data),
    .sample_vld (wr_fire),
    .level      (bus.trig_level),
    .rising     (bus.trig_edge),
    .hit        (hit)
  );

`ifdef AUTO_TRIG_EN
  logic [31:0] arm_cnt;
  logic        trig_auto_q;

  assign auto_hit = (arm_cnt == 32'(AUTO_TO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt     <= '0;
      trig_auto_q <= 1'b0;
    end else begin
      if (state != ARM) begin
        arm_cnt <= '0;
      end else if (wr_fire) begin
        arm_cnt <= arm_cnt + 32'd1;
      end
      // A real edge on the timeout sample wins, so trig_auto stays 0 then.
      if (enter_pre) begin
        trig_auto_q <= 1'b0;
      end else if (trig_fire && !hit) begin
        trig_auto_q <= 1'b1;
      end
    end
  end

  assign bus.trig_auto = trig_auto_q;
`else
  assign auto_hit      = 1'b0;
  assign bus.trig_auto = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.wave_run) next_state = PRE;
      PRE: begin
        if (!bus.wave_run)                   next_state = IDLE;
        else if (wr_fire && cnt == PRE_LAST) next_state = ARM;
      end
      ARM: begin
        if (!bus.wave_run) next_state = IDLE;
        else if (trig_fire) next_state = POST;
      end
      POST: begin
        if (!bus.wave_run)                    next_state = IDLE;
        else if (wr_fire && cnt == POST_LAST) next_state = DONE;
      end
      DONE: if (bus.rd_done) next_state = bus.wave_run ? PRE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deci_cnt     <= '0;
      cnt          <= '0;
      wr_ptr       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      acq_done_q   <= 1'b0;
    end else begin
      // >= rather than == so a lowered deci_rate wraps immediately.
      if (enter_pre || deci_cnt >= deci_last) begin
        deci_cnt <= '0;
      end else begin
        deci_cnt <= deci_cnt + 10'd1;
      end
      // cnt is a per-phase sample count, restarted at every state change.
      if (next_state != state) begin
        cnt <= '0;
      end else if (wr_fire) begin
        cnt <= cnt + 1'b1;
      end
      wr_en_q <= wr_fire;
      if (wr_fire) begin
        wr_addr_q <= wr_ptr;
        wr_data_q <= bus.ad_data;
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (trig_fire) begin
        trig_addr_q  <= wr_ptr;
        start_addr_q <= wr_ptr - PRE_OFS;
      end
      // Rises one cycle after the final POST write is presented.
      acq_done_q <= (state == DONE) && (next_state == DONE);
    end
  end

  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_addr = wr_addr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign bus.trig_addr   = trig_addr_q;
  assign bus.start_addr  = start_addr_q;
  assign bus.acq_done    = acq_done_q;
  assign bus.acq_state   = state;

endmodule

// File: tb/tb_wave_acq_ctrl.sv
// tb/tb_wave_acq_ctrl.sv - self-checking bench for wave_acq_ctrl
module tb_wave_acq_ctrl;
  import wave_acq_pkg::*;

  localparam int DW    = 10;
  localparam int PRE_N = 512;
  localparam int DEPTH = 1 << DW;
  localparam int POSTN = DEPTH - PRE_N - 1;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int deci;
    bit rising;
    int level;
    int kind;      // 0 ramp up, 1 ramp down, 2 constant 50
    int trig_j;    // index within frame of the expected trigger sample
    bit exp_auto;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wave_acq_ctrl_if #(.DEPTH_W(DW)) bus ();

  wave_acq_ctrl #(.DEPTH_W(DW), .PRE_TRIG(PRE_N), .AUTO_TO(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t sb[$];
  int  total_n  = 0;
  int  bad_n    = 0;
  int  cyc      = 0;
  int  last_wr  = -1;
  int  exp_gap  = 0;
  int  cyc0     = 0;
  int  wr_count = 0;
  int  exp_ptr  = 0;
  bit  chk_first = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int pat(input int kind, input int j);
    case (kind)
      0:       return j % 256;
      1:       return 255 - (j % 256);
      default: return 50;
    endcase
  endfunction

  // One clock; sample outputs on the falling edge and score RAM writes.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    cyc++;
    if (bus.ram_wr_en) begin
      wr_count++;
      check("wr_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check("wr_addr", int'(bus.ram_wr_addr), w.addr);
        check("wr_data", int'(bus.ram_wr_data), w.data);
      end
      if (last_wr >= 0 && exp_gap > 0) check("wr_gap", cyc - last_wr, exp_gap);
      else if (last_wr < 0 && chk_first) check("first_wr_lat", cyc - cyc0, 2);
      last_wr = cyc;
    end
  endtask

  task automatic run_frame(input frame_t f, input bit from_idle);
    int n, total, base, c, bound;
    bit done;
    n     = (f.deci == 0) ? 1 : f.deci;
    total = f.trig_j + 1 + POSTN;
    base  = exp_ptr;
    bus.deci_rate  = 10'(f.deci);
    bus.trig_edge  = f.rising;
    bus.trig_level = 8'(f.level);
    bus.wave_run   = 1'b1;
    if (!from_idle) bus.rd_done = 1'b1;
    for (int j = 0; j < total; j++) sb.push_back('{(base + j) % DEPTH, pat(f.kind, j)});
    cyc0 = cyc; last_wr = -1; exp_gap = n; chk_first = 1'b1; wr_count = 0;
    tick();
    bus.rd_done = 1'b0;
    check("pre_entry_state", int'(bus.acq_state), 1);
    check("pre_entry_done", int'(bus.acq_done), 0);
    c = 0; done = 1'b0; bound = total * n + 50;
    while (!done && c < bound) begin
      bus.ad_data = (c % n == 0) ? 8'(pat(f.kind, c / n)) : ((c % 2 == 1) ? 8'd0 : 8'd255);
      tick();
      c++;
      if (bus.acq_done) done = 1'b1;
    end
    check("frame_done", int'(done), 1);
    check("done_lat", cyc - last_wr, 1);
    check("wr_total", wr_count, total);
    check("sb_empty", sb.size(), 0);
    check("trig_addr", int'(bus.trig_addr), (base + f.trig_j) % DEPTH);
    check("start_addr", int'(bus.start_addr), (base + f.trig_j - PRE_N + 2 * DEPTH) % DEPTH);
    check("trig_auto", int'(bus.trig_auto), int'(f.exp_auto));
    check("done_state", int'(bus.acq_state), 4);
    sb.delete();
    exp_ptr = (base + total) % DEPTH;
    chk_first = 1'b0; exp_gap = 0;
    bus.wave_run = 1'b0;
    repeat (3) tick();
    check("done_hold_state", int'(bus.acq_state), 4);
    check("done_hold_flag", int'(bus.acq_done), 1);
  endtask

  frame_t ft[4];
  frame_t fa;
  bit     saw_done;
  int     base;

  initial begin
    ft[0] = '{1, 1'b1, 128, 0, 640, 1'b0};
    ft[1] = '{4, 1'b0, 100, 1, 668, 1'b0};
    ft[2] = '{0, 1'b1, 255, 0, 767, 1'b0};
    ft[3] = '{3, 1'b0, 100, 1, 668, 1'b0};

    bus.ad_data = 8'd0; bus.deci_rate = 10'd1; bus.trig_level = 8'd128;
    bus.trig_edge = 1'b1; bus.wave_run = 1'b0; bus.rd_done = 1'b0;

    repeat (3) tick();
    check("rst_wr_en", int'(bus.ram_wr_en), 0);
    check("rst_wr_addr", int'(bus.ram_wr_addr), 0);
    check("rst_wr_data", int'(bus.ram_wr_data), 0);
    check("rst_trig_addr", int'(bus.trig_addr), 0);
    check("rst_start_addr", int'(bus.start_addr), 0);
    check("rst_acq_done", int'(bus.acq_done), 0);
    check("rst_trig_auto", int'(bus.trig_auto), 0);
    check("rst_state", int'(bus.acq_state), 0);
    rst = 1'b0;
    tick();
    check("idle_state", int'(bus.acq_state), 0);

    for (int i = 0; i < 4; i++) run_frame(ft[i], i == 0);

    // DONE + rd_done with run low returns to IDLE.
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    check("rearm_off_state", int'(bus.acq_state), 0);
    check("rearm_off_done", int'(bus.acq_done), 0);

    // Stop in ARM; rd_done while in ARM is ignored.
    bus.deci_rate = 10'd1; bus.trig_edge = 1'b1; bus.trig_level = 8'd128;
    bus.wave_run = 1'b1; base = exp_ptr;
    for (int j = 0; j < 521; j++) sb.push_back('{(base + j) % DEPTH, 50});
    cyc0 = cyc; last_wr = -1; exp_gap = 1; chk_first = 1'b1;
    tick();
    for (int c = 0; c < 520; c++) begin
      bus.ad_data = 8'd50;
      tick();
    end
    check("arm_state", int'(bus.acq_state), 2);
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    check("arm_rd_done_ignored", int'(bus.acq_state), 2);
    bus.wave_run = 1'b0;
    tick();
    check("stop_state", int'(bus.acq_state), 0);
    repeat (5) tick();
    check("stop_sb_empty", sb.size(), 0);
    check("stop_done", int'(bus.acq_done), 0);
    exp_ptr = (base + 521) % DEPTH;
    chk_first = 1'b0;

`ifdef AUTO_TRIG_EN
    fa = '{1, 1'b1, 128, 2, 512 + 4095, 1'b1};
    run_frame(fa, 1'b1);
    bus.rd_done = 1'b1; bus.wave_run = 1'b1;
    tick();
    bus.rd_done = 1'b0; bus.wave_run = 1'b0;
    check("auto_clear_on_pre", int'(bus.trig_auto), 0);
    tick();
    check("auto_after_stop", int'(bus.acq_state), 0);
`else
    // Without the forced trigger, a flat signal never completes a frame.
    fa = '{1, 1'b1, 128, 2, 0, 1'b0};
    bus.deci_rate = 10'(fa.deci); bus.trig_edge = fa.rising; bus.trig_level = 8'(fa.level);
    bus.wave_run = 1'b1; base = exp_ptr; saw_done = 1'b0;
    cyc0 = cyc; last_wr = -1; exp_gap = 1; chk_first = 1'b1;
    tick();
    for (int c = 0; c < 6000; c++) begin
      sb.push_back('{(base + c) % DEPTH, pat(fa.kind, c)});
      bus.ad_data = 8'(pat(fa.kind, c));
      tick();
      if (bus.acq_done) saw_done = 1'b1;
    end
    check("noauto_done", int'(saw_done), 0);
    check("noauto_flag", int'(bus.trig_auto), 0);
    check("noauto_state", int'(bus.acq_state), 2);
    bus.wave_run = 1'b0;
    tick();
    check("noauto_stop", int'(bus.acq_state), 0);
    check("noauto_sb_empty", sb.size(), 0);
    exp_ptr = (base + 6000) % DEPTH;
    chk_first = 1'b0;
`endif

    // Reset in POST discards the frame; pointer restarts at 0.
    bus.deci_rate = 10'd1; bus.trig_edge = 1'b1; bus.trig_level = 8'd128;
    bus.wave_run = 1'b1; base = exp_ptr; last_wr = -1; exp_gap = 1;
    tick();
    for (int c = 0; c < 800; c++) begin
      sb.push_back('{(base + c) % DEPTH, c % 256});
      bus.ad_data = 8'(c % 256);
      tick();
    end
    check("mid_post_state", int'(bus.acq_state), 3);
    rst = 1'b1;
    #1;
    check("mrst_wr_en", int'(bus.ram_wr_en), 0);
    check("mrst_wr_addr", int'(bus.ram_wr_addr), 0);
    check("mrst_trig_addr", int'(bus.trig_addr), 0);
    check("mrst_start_addr", int'(bus.start_addr), 0);
    check("mrst_state", int'(bus.acq_state), 0);
    sb.delete();
    tick();
    rst = 1'b0;
    cyc0 = cyc; last_wr = -1; chk_first = 1'b1;
    for (int j = 0; j < 5; j++) sb.push_back('{j, 7});
    tick();
    check("restart_state", int'(bus.acq_state), 1);
    for (int c = 0; c < 5; c++) begin
      bus.ad_data = 8'd7;
      tick();
    end
    bus.wave_run = 1'b0;
    tick();
    check("restart_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
